button_click_classifier: RTL and testbench
==========================================

// Module: button_click_classifier
//
// PURPOSE
//  Sits directly downstream of button_debouncer, in the same divided-clock domain (400 Hz tick clock).
//  Consumes the debounced level and press pulse and classifies each gesture as single click, double click or long press.
//  Emits one registered one-cycle event pulse per gesture, plus a latched last-event code and a wrapping event counter for the LEDs.
//
// PARAMETERS
//  CNT_W       9    width of the internal tick counter
//  LONG_TICKS  400  hold ticks that make a long press (1 s @ 400 Hz); 2..2^CNT_W-1
//  GAP_TICKS   100  max release ticks before a 2nd press (250 ms @ 400 Hz); 2..2^CNT_W-1
//
// PORTS
//  clk          in   1  debounced-domain clock (divided 400 Hz clock)
//  rst          in   1  synchronous, active-high reset
//  b_level      in   1  debounced button level, 1 = pressed
//  b_pulse      in   1  one-cycle press pulse, coincident with b_level 0->1
//  single_click out  1  one-cycle pulse: single click classified
//  double_click out  1  one-cycle pulse: double click classified
//  long_press   out  1  one-cycle pulse: long press classified
//  last_event   out  2  latched code: 00 none, 01 single, 10 double, 11 long
//  event_count  out  8  count of classified events, wraps 255->0
//
// BEHAVIOUR
//  Reset:
//   - rst=1 at a clk edge forces state IDLE, cnt=0 and all outputs to 0.
//   - Reset wins over every other condition, including mid-gesture; a pending gesture is discarded, not reported.
//  Outputs:
//   - All outputs are registered.
//   - An event pulse is high for exactly the cycle after the transition that classifies it.
//   - Any cycle has at most one event pulse.
//   - last_event and event_count update on that same cycle.
//  FSM states (cnt = CNT_W-bit tick counter; a state change always reloads cnt to 0):
//   IDLE:
//    - b_pulse=1 -> PRESS1.
//    - Otherwise stay. b_level alone never starts a gesture.
//   PRESS1:
//    - b_level=0 -> GAP.
//    - Else if cnt==LONG_TICKS-1 -> LONG and emit long_press.
//    - Else cnt++.
//    - A press of exactly LONG_TICKS ticks is long. A release on the LONG_TICKS-th cycle is not long.
//   GAP:
//    - b_pulse=1 -> PRESS2.
//    - Else if cnt==GAP_TICKS-1 -> IDLE and emit single_click.
//    - Else cnt++.
//    - If b_pulse and the timeout fall in the same cycle, b_pulse wins: PRESS2, no single_click.
//   PRESS2:
//    - b_level=0 -> IDLE and emit double_click.
//    - Holding in PRESS2 never produces long_press; cnt is held at 0.
//   LONG:
//    - b_level=0 -> IDLE, no further event.
//    - b_pulse in LONG is ignored.
//  Further rules:
//   - b_pulse while b_level is already 1, in PRESS1 or PRESS2, is ignored (protocol violation tolerated).
//   - cnt never wraps: every counting state exits at or before its terminal value.
//   - event_count increments by 1 per event and is modulo 256.
//   - Latency, press-edge to long_press: LONG_TICKS+1 cycles after the b_pulse cycle.
//   - Latency, release to single_click: GAP_TICKS+1 cycles.
//
// TESTING  (bench params: LONG_TICKS=8, GAP_TICKS=4)
//  1. Press 3 cycles, release, idle 10 -> single_click once, 5 cycles after release; last_event=01; event_count=1.
//  2. Press 3, release 2, press 3, release -> double_click 1 cycle after 2nd release; no single_click; last_event=10.
//  3. Hold 20 cycles -> long_press 9 cycles after b_pulse; release -> no extra pulse; last_event=11.
//  4. Hold exactly 8 cycles vs 7 cycles -> 8 gives long_press; 7 gives single_click after the gap.
//  5. Release so the 2nd b_pulse lands on gap cnt==3 -> PRESS2 taken; release gives double_click; no single_click.
//  6. rst=1 mid-PRESS1 for one cycle -> outputs 0 next cycle; no event reported.
//  7. 256 single clicks -> event_count returns to 0.

Source files
------------

// File: rtl/button_click_classifier.sv
// Classifies debounced button gestures as single click, double click or long press.
// Emits one registered pulse per gesture plus a latched last-event code and an event counter.
module button_click_classifier #(
  parameter int unsigned CNT_W      = 9,
  parameter int unsigned LONG_TICKS = 400,
  parameter int unsigned GAP_TICKS  = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       b_level,
  input  logic       b_pulse,
  output logic       single_click,
  output logic       double_click,
  output logic       long_press,
  output logic [1:0] last_event,
  output logic [7:0] event_count
);

  typedef enum logic [2:0] {
    StIdle,
    StPress1,
    StGap,
    StPress2,
    StLong
  } state_e;

  localparam logic [1:0] EvNone   = 2'b00;
  localparam logic [1:0] EvSingle = 2'b01;
  localparam logic [1:0] EvDouble = 2'b10;
  localparam logic [1:0] EvLong   = 2'b11;

  localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] GapLast  = CNT_W'(GAP_TICKS - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ev_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ev_d    = EvNone;
    unique case (state_q)
      StIdle: begin
        if (b_pulse) begin
          state_d = StPress1;
          cnt_d   = '0;
        end
      end
      StPress1: begin
        if (!b_level) begin
          state_d = StGap;
          cnt_d   = '0;
        end else if (cnt_q == LongLast) begin
          state_d = StLong;
          cnt_d   = '0;
          ev_d    = EvLong;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        // A second press landing on the timeout cycle still counts as a double click.
        if (b_pulse) begin
          state_d = StPress2;
          cnt_d   = '0;
        end else if (cnt_q == GapLast) begin
          state_d = StIdle;
          cnt_d   = '0;
          ev_d    = EvSingle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StPress2: begin
        cnt_d = '0;
        if (!b_level) begin
          state_d = StIdle;
          ev_d    = EvDouble;
        end
      end
      StLong: begin
        if (!b_level) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      single_click <= 1'b0;
      double_click <= 1'b0;
      long_press   <= 1'b0;
      last_event   <= EvNone;
      event_count  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      single_click <= (ev_d == EvSingle);
      double_click <= (ev_d == EvDouble);
      long_press   <= (ev_d == EvLong);
      if (ev_d != EvNone) begin
        last_event  <= ev_d;
        event_count <= event_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_button_click_classifier.sv
// Bench for button_click_classifier: gestures described as (hold, release) pairs,
// expected events derived from press/gap durations and compared every cycle.
module tb_button_click_classifier;

  localparam int LONG = 8;
  localparam int GAP  = 4;
  localparam int MAXL = 4096;

  logic       clk;
  logic       rst;
  logic       b_level;
  logic       b_pulse;
  logic       single_click;
  logic       double_click;
  logic       long_press;
  logic [1:0] last_event;
  logic [7:0] event_count;

  int n_cmp;
  int n_bad;

  // hold_a: cycles b_level stays high after the b_pulse cycle; rel_a: low cycles that follow
  int hold_a [300];
  int rel_a  [300];
  bit lvl    [MAXL];
  bit pls    [MAXL];
  logic [1:0] expv [MAXL];
  logic [1:0] exp_last;
  logic [7:0] exp_count;
  bit spur;

  button_click_classifier #(
    .CNT_W     (9),
    .LONG_TICKS(LONG),
    .GAP_TICKS (GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .b_level     (b_level),
    .b_pulse     (b_pulse),
    .single_click(single_click),
    .double_click(double_click),
    .long_press  (long_press),
    .last_event  (last_event),
    .event_count (event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] ev);
    check({tag, ".single"}, 8'(single_click), 8'(ev == 2'd1));
    check({tag, ".double"}, 8'(double_click), 8'(ev == 2'd2));
    check({tag, ".long"},   8'(long_press),   8'(ev == 2'd3));
    check({tag, ".last"},   8'(last_event),   8'(exp_last));
    check({tag, ".count"},  event_count,      exp_count);
  endtask

  // Edge index k means the output registered at the k-th sampled edge of the sequence.
  task automatic run_seq(input string tag, input int n);
    int t;
    int t1;
    int i;
    int len;
    for (int k = 0; k < MAXL; k++) begin
      lvl[k]  = 1'b0;
      pls[k]  = 1'b0;
      expv[k] = 2'd0;
    end
    t = 0;
    for (int p = 0; p < n; p++) begin
      pls[t] = 1'b1;
      for (int k = 0; k <= hold_a[p]; k++) begin
        lvl[t+k] = 1'b1;
        if (spur && k > 0 && $urandom_range(0, 5) == 0) pls[t+k] = 1'b1;
      end
      t += hold_a[p] + 1 + rel_a[p];
    end
    len = t;
    t = 0;
    i = 0;
    while (i < n) begin
      if (hold_a[i] >= LONG) begin
        expv[t+LONG] = 2'd3;
        t += hold_a[i] + 1 + rel_a[i];
        i++;
      end else if (rel_a[i] <= GAP && i + 1 < n) begin
        t1 = t + hold_a[i] + 1 + rel_a[i];
        expv[t1+hold_a[i+1]+1] = 2'd2;
        t = t1 + hold_a[i+1] + 1 + rel_a[i+1];
        i += 2;
      end else begin
        expv[t+hold_a[i]+1+GAP] = 2'd1;
        t += hold_a[i] + 1 + rel_a[i];
        i++;
      end
    end
    for (int c = 0; c < len; c++) begin
      @(negedge clk);
      b_level = lvl[c];
      b_pulse = pls[c];
      @(posedge clk);
      #1;
      if (expv[c] != 2'd0) begin
        exp_last = expv[c];
        exp_count++;
      end
      check_all(tag, expv[c]);
    end
    @(negedge clk);
    b_level = 1'b0;
    b_pulse = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    spur      = 1'b0;
    exp_last  = 2'd0;
    exp_count = 8'd0;
    rst       = 1'b1;
    b_level   = 1'b0;
    b_pulse   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 2'd0);
    @(negedge clk);
    rst = 1'b0;

    hold_a[0] = 2; rel_a[0] = 20;
    run_seq("single", 1);

    hold_a[0] = 2; rel_a[0] = 2;
    hold_a[1] = 2; rel_a[1] = 20;
    run_seq("double", 2);

    hold_a[0] = 20; rel_a[0] = 20;
    run_seq("long", 1);

    hold_a[0] = 8; rel_a[0] = 20;
    hold_a[1] = 7; rel_a[1] = 20;
    run_seq("long_edge", 2);

    hold_a[0] = 2; rel_a[0] = GAP;
    hold_a[1] = 2; rel_a[1] = GAP + 1;
    hold_a[2] = 1; rel_a[2] = 20;
    run_seq("gap_edge", 3);

    // Reset in the middle of a first press discards the gesture.
    @(negedge clk);
    b_level = 1'b1;
    b_pulse = 1'b1;
    @(negedge clk);
    b_pulse = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    exp_last  = 2'd0;
    exp_count = 8'd0;
    check_all("mid_reset", 2'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    b_level = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      check_all("post_reset", 2'd0);
    end

    for (int p = 0; p < 256; p++) begin
      hold_a[p] = 0;
      rel_a[p]  = (p == 255) ? 20 : GAP + 1;
    end
    run_seq("wrap", 256);
    check("count_wrap", event_count, 8'd0);

    spur = 1'b1;
    for (int p = 0; p < 40; p++) begin
      hold_a[p] = $urandom_range(0, 12);
      rel_a[p]  = (p == 39) ? 20 : $urandom_range(1, 8);
    end
    run_seq("random", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
